pg_domain_ctrl: RTL and testbench
=================================

PG_DOMAIN_CTRL -- requirements
Module: pg_domain_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DOM, default 4, number of independently gated power domains.
REQ-002 The block SHALL have parameter IDLE_W, default 8, width of the idle threshold and per-domain idle counters.
REQ-003 The block SHALL have parameter WAKE_LAT, default 2 (legal range 1..15), number of cycles a domain spends in WAKE.
REQ-004 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port activity  input  NUM_DOM  bit i high = domain i has work this cycle.
REQ-007 The block SHALL have port force_on  input  1  global override: no gating, wake any gated domain.
REQ-008 The block SHALL have port idle_thresh  input  IDLE_W  consecutive idle cycles before gating; 0 disables gating.
REQ-009 The block SHALL have port pwr_en  output  NUM_DOM  bit i high = domain i powered.
REQ-010 The block SHALL have port iso_en  output  NUM_DOM  bit i high = domain i outputs isolated (clamped).
REQ-011 The block SHALL have port dom_ready  output  NUM_DOM  bit i high = domain i in ON state.

Function
REQ-012 Each domain SHALL run an independent FSM with states ON, ISO, OFF, WAKE; outputs decoded from state only (Moore).
REQ-013 Output decode SHALL be: ON pwr=1 iso=0 ready=1; ISO pwr=1 iso=1 ready=0; OFF pwr=0 iso=1 ready=0; WAKE pwr=1 iso=1 ready=0.
REQ-014 In ON, a sampled activity[i]=1 or force_on=1 SHALL clear idle counter i to 0.
REQ-015 In ON with activity[i]=0, force_on=0, idle_thresh!=0: if cnt+1 >= idle_thresh, next state ISO and cnt cleared; else cnt increments, saturating at 2^IDLE_W-1.
REQ-016 With idle_thresh=3 and activity[i] low at edges 1,2,3, domain i SHALL be in ISO after edge 3 and OFF after edge 4.
REQ-017 ISO SHALL last exactly one cycle: next state ON if activity[i] or force_on sampled high, else OFF.
REQ-018 OFF SHALL persist until activity[i] or force_on sampled high, then next state WAKE.
REQ-019 WAKE SHALL last exactly WAKE_LAT cycles regardless of activity, then ON with cnt=0; activity during WAKE SHALL be ignored.
REQ-020 pwr_en SHALL rise on the edge entering WAKE; iso_en SHALL stay high until the edge entering ON (isolation released only after power stable).
REQ-021 idle_thresh changes SHALL take effect on the next comparison; lowering it below the current count gates at the next idle cycle.
REQ-022 Domains SHALL never interact; simultaneous transitions in several domains are legal.

Reset
REQ-023 rst_n low SHALL asynchronously force every domain to ON: pwr_en all 1, iso_en all 0, dom_ready all 1, all counters 0.
REQ-024 Reset asserted in any state (including OFF or WAKE) SHALL take effect immediately without passing through WAKE.
REQ-025 After rst_n deassertion, first state update SHALL occur on the following rising clk edge.

Configuration
REQ-026 Macro PG_STATS_EN SHALL, when defined, add outputs total_cycles (32, output) and gated_cycles (32, output).
REQ-027 With PG_STATS_EN: total_cycles increments every post-reset cycle; gated_cycles increments each cycle any pwr_en bit is 0; both wrap at 2^32, reset to 0.
REQ-028 Without PG_STATS_EN the ports and counters SHALL not exist; all other behaviour identical.

Verification (NUM_DOM=4, IDLE_W=8, WAKE_LAT=2, idle_thresh=3)
REQ-029 Reset: rst_n low while domain 0 OFF -> pwr_en=4'hF, iso_en=4'h0, dom_ready=4'hF immediately, before any clk edge.
REQ-030 Gating: activity=4'hE held -> after edge 3 iso_en=4'h1, pwr_en=4'hF; after edge 4 pwr_en=4'hE; domains 1-3 unchanged.
REQ-031 Wake: domain 0 OFF, activity[0]=1 one cycle -> next edge pwr_en=4'hF, iso_en=4'h1; two edges later iso_en=4'h0, dom_ready=4'hF.
REQ-032 Abort: activity[0] high while domain 0 in ISO -> next edge ON, pwr_en[0] never drops.
REQ-033 Disable/override: idle_thresh=0, activity=0 for 100 cycles -> pwr_en stays 4'hF; then idle_thresh=3 gating all, force_on=1 -> all domains WAKE then ON.
REQ-034 Stats (PG_STATS_EN): 10 cycles after reset with domain 0 OFF for 4 of them -> total_cycles=10, gated_cycles=4.

Source files
------------

// File: rtl/pg_domain_ctrl.sv
// Per-domain power-gating controller: idle-count gating, one-cycle isolation, timed wake.
// Optional activity statistics are compiled in with `define PG_STATS_EN.
module pg_dom_fsm #(
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              act_i,
  input  logic              force_i,
  input  logic [IDLE_W-1:0] thresh_i,
  output logic              pwr_o,
  output logic              iso_o,
  output logic              rdy_o
);
  localparam logic [1:0] S_ON   = 2'd0;
  localparam logic [1:0] S_ISO  = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;
  localparam logic [1:0] S_WAKE = 2'd3;
  localparam logic [3:0] WAKE_LAST = 4'(WAKE_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [IDLE_W-1:0] cnt_q, cnt_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [IDLE_W:0]   cnt_inc;
  logic              wake;

  assign wake    = act_i | force_i;
  // One extra bit so the threshold compare cannot wrap at the counter ceiling.
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_ON: begin
        if (wake) begin
          cnt_d = '0;
        end else if (thresh_i != '0) begin
          if (cnt_inc >= {1'b0, thresh_i}) begin
            state_d = S_ISO;
            cnt_d   = '0;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ISO:  state_d = wake ? S_ON : S_OFF;
      S_OFF: begin
        if (wake) begin
          state_d = S_WAKE;
          wcnt_d  = '0;
        end
      end
      default: begin
        // Activity is deliberately ignored while power ramps.
        if (wcnt_q == WAKE_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ON;
      cnt_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign pwr_o = (state_q != S_OFF);
  assign iso_o = (state_q != S_ON);
  assign rdy_o = (state_q == S_ON);
endmodule

module pg_domain_ctrl #(
  parameter int NUM_DOM  = 4,
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_DOM-1:0] activity,
  input  logic               force_on,
  input  logic [IDLE_W-1:0]  idle_thresh,
  output logic [NUM_DOM-1:0] pwr_en,
  output logic [NUM_DOM-1:0] iso_en,
  output logic [NUM_DOM-1:0] dom_ready
`ifdef PG_STATS_EN
  ,
  output logic [31:0]        total_cycles,
  output logic [31:0]        gated_cycles
`endif
);
  for (genvar i = 0; i < NUM_DOM; i++) begin : g_dom
    pg_dom_fsm #(.IDLE_W(IDLE_W), .WAKE_LAT(WAKE_LAT)) u_fsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .act_i    (activity[i]),
      .force_i  (force_on),
      .thresh_i (idle_thresh),
      .pwr_o    (pwr_en[i]),
      .iso_o    (iso_en[i]),
      .rdy_o    (dom_ready[i])
    );
  end

`ifdef PG_STATS_EN
  logic [31:0] total_q, gated_q;

  // A cycle counts as gated when any domain is unpowered during it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
      gated_q <= '0;
    end else begin
      total_q <= total_q + 32'd1;
      if (!(&pwr_en)) gated_q <= gated_q + 32'd1;
    end
  end

  assign total_cycles = total_q;
  assign gated_cycles = gated_q;
`endif
endmodule

// File: tb/tb_pg_domain_ctrl.sv
// Bench for pg_domain_ctrl: directed table, corner sequences, randomized run against a model.
module tb_pg_domain_ctrl;
  localparam int ND = 4;
  localparam int IW = 8;
  localparam int WL = 2;
  localparam int M_ON = 0, M_ISO = 1, M_OFF = 2, M_WAKE = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [ND-1:0] activity;
  logic          force_on;
  logic [IW-1:0] idle_thresh;
  logic [ND-1:0] pwr_en, iso_en, dom_ready;
`ifdef PG_STATS_EN
  logic [31:0]   total_cycles, gated_cycles;
`endif

  pg_domain_ctrl #(.NUM_DOM(ND), .IDLE_W(IW), .WAKE_LAT(WL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .activity    (activity),
    .force_on    (force_on),
    .idle_thresh (idle_thresh),
    .pwr_en      (pwr_en),
    .iso_en      (iso_en),
    .dom_ready   (dom_ready)
`ifdef PG_STATS_EN
    ,
    .total_cycles(total_cycles),
    .gated_cycles(gated_cycles)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference: each domain's mode, its idle run length and remaining wake time.
  int mode [ND];
  int idle [ND];
  int wleft[ND];
  int m_total, m_gated;

  typedef struct {
    logic [ND-1:0] act;
    logic          frc;
    logic [IW-1:0] th;
    logic [ND-1:0] pwr;
    logic [ND-1:0] iso;
    logic [ND-1:0] rdy;
  } vec_t;
  vec_t tbl[24];

  function automatic vec_t mk(logic [ND-1:0] a, logic f, logic [IW-1:0] t,
                              logic [ND-1:0] p, logic [ND-1:0] s, logic [ND-1:0] r);
    vec_t v;
    v.act = a; v.frc = f; v.th = t; v.pwr = p; v.iso = s; v.rdy = r;
    return v;
  endfunction

  task automatic check(input string name, input logic [3*ND-1:0] got, input logic [3*ND-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got pwr/iso/rdy=%h required %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d required %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [3*ND-1:0] model_out();
    logic [ND-1:0] p, s, r;
    for (int i = 0; i < ND; i++) begin
      p[i] = (mode[i] != M_OFF);
      s[i] = (mode[i] != M_ON);
      r[i] = (mode[i] == M_ON);
    end
    return {p, s, r};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      mode[i] = M_ON; idle[i] = 0; wleft[i] = 0;
    end
    m_total = 0; m_gated = 0;
  endtask

  task automatic model_step(input logic [ND-1:0] a, input logic f, input logic [IW-1:0] th);
    bit any_off = 0;
    for (int i = 0; i < ND; i++) if (mode[i] == M_OFF) any_off = 1;
    m_total++;
    if (any_off) m_gated++;
    for (int i = 0; i < ND; i++) begin
      bit busy = a[i] | f;
      case (mode[i])
        M_ON: begin
          if (busy) idle[i] = 0;
          else if (th != 0) begin
            if (idle[i] + 1 >= int'(th)) begin mode[i] = M_ISO; idle[i] = 0; end
            else idle[i]++;
          end
        end
        M_ISO: mode[i] = busy ? M_ON : M_OFF;
        M_OFF: if (busy) begin mode[i] = M_WAKE; wleft[i] = WL; end
        default: begin
          wleft[i]--;
          if (wleft[i] == 0) begin mode[i] = M_ON; idle[i] = 0; end
        end
      endcase
    end
  endtask

  task automatic drive(input logic [ND-1:0] a, input logic f, input logic [IW-1:0] t);
    activity = a; force_on = f; idle_thresh = t;
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic cyc(input string name);
    model_step(activity, force_on, idle_thresh);
    @(posedge clk);
    #1;
    check(name, {pwr_en, iso_en, dom_ready}, model_out());
`ifdef PG_STATS_EN
    check32({name, "_total"}, total_cycles, m_total);
    check32({name, "_gated"}, gated_cycles, m_gated);
`endif
  endtask

  // Assert reset mid-cycle, check the forced values before any edge, release before the next edge.
  task automatic mid_reset(input string name);
    #2 rst_n = 1'b0;
    #1;
    check(name, {pwr_en, iso_en, dom_ready}, {4'hF, 4'h0, 4'hF});
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = mk(4'hE, 0, 3, 4'hF, 4'h0, 4'hF);
    tbl[1]  = mk(4'hE, 0, 3, 4'hF, 4'h0, 4'hF);
    tbl[2]  = mk(4'hE, 0, 3, 4'hF, 4'h1, 4'hE);
    tbl[3]  = mk(4'hE, 0, 3, 4'hE, 4'h1, 4'hE);
    tbl[4]  = mk(4'hE, 0, 3, 4'hE, 4'h1, 4'hE);
    tbl[5]  = mk(4'hF, 0, 3, 4'hF, 4'h1, 4'hE);
    tbl[6]  = mk(4'hE, 0, 3, 4'hF, 4'h1, 4'hE);
    tbl[7]  = mk(4'hE, 0, 3, 4'hF, 4'h0, 4'hF);
    tbl[8]  = mk(4'hE, 0, 3, 4'hF, 4'h0, 4'hF);
    tbl[9]  = mk(4'hE, 0, 3, 4'hF, 4'h0, 4'hF);
    tbl[10] = mk(4'hE, 0, 3, 4'hF, 4'h1, 4'hE);
    tbl[11] = mk(4'hF, 0, 3, 4'hF, 4'h0, 4'hF);
    tbl[12] = mk(4'h0, 0, 3, 4'hF, 4'h0, 4'hF);
    tbl[13] = mk(4'h0, 0, 3, 4'hF, 4'h0, 4'hF);
    tbl[14] = mk(4'h0, 0, 3, 4'hF, 4'hF, 4'h0);
    tbl[15] = mk(4'h0, 0, 3, 4'h0, 4'hF, 4'h0);
    tbl[16] = mk(4'h0, 1, 3, 4'hF, 4'hF, 4'h0);
    tbl[17] = mk(4'h0, 1, 3, 4'hF, 4'hF, 4'h0);
    tbl[18] = mk(4'h0, 0, 3, 4'hF, 4'h0, 4'hF);
    tbl[19] = mk(4'h0, 0, 5, 4'hF, 4'h0, 4'hF);
    tbl[20] = mk(4'h0, 0, 5, 4'hF, 4'h0, 4'hF);
    tbl[21] = mk(4'h0, 0, 5, 4'hF, 4'h0, 4'hF);
    tbl[22] = mk(4'h0, 0, 2, 4'hF, 4'hF, 4'h0);
    tbl[23] = mk(4'hF, 0, 2, 4'hF, 4'h0, 4'hF);

    rst_n = 1'b0;
    drive(4'h0, 1'b0, 8'd3);
    model_reset();
    #2;
    check("reset_before_edge", {pwr_en, iso_en, dom_ready}, {4'hF, 4'h0, 4'hF});
    #10 rst_n = 1'b1;
    #1;

    // Directed table: gating, wake, abort, all-domain gating, force wake, threshold lowering.
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].act, tbl[i].frc, tbl[i].th);
      model_step(activity, force_on, idle_thresh);
      @(posedge clk);
      #1;
      check($sformatf("table[%0d]", i), {pwr_en, iso_en, dom_ready}, {tbl[i].pwr, tbl[i].iso, tbl[i].rdy});
    end

    // Async reset while domain 0 is OFF.
    drive(4'hE, 1'b0, 8'd3);
    for (int i = 0; i < 4; i++) cyc("to_off");
    check("d0_off_before_reset", {pwr_en, iso_en}, {4'hE, 4'h1});
    mid_reset("async_rst_in_off");

    // Async reset while domain 0 is in WAKE; afterwards it must be ON without a wake phase.
    drive(4'hE, 1'b0, 8'd3);
    for (int i = 0; i < 4; i++) cyc("to_off2");
    drive(4'hF, 1'b0, 8'd3);
    cyc("enter_wake");
    mid_reset("async_rst_in_wake");
    cyc("on_after_wake_reset");

    // Gating disabled for 100 idle cycles, then gate everything and force a wake.
    drive(4'h0, 1'b0, 8'd0);
    for (int i = 0; i < 100; i++) cyc("thresh0_hold");
    drive(4'h0, 1'b0, 8'd3);
    for (int i = 0; i < 4; i++) cyc("gate_all");
    check("all_off", pwr_en, 4'h0);
    drive(4'h0, 1'b1, 8'd3);
    for (int i = 0; i < 3; i++) cyc("force_wake");
    check("force_all_on", dom_ready, 4'hF);

`ifdef PG_STATS_EN
    // Ten post-reset cycles with domain 0 unpowered for four of them.
    mid_reset("stats_reset");
    drive(4'hE, 1'b0, 8'd3);
    for (int i = 0; i < 7; i++) cyc("stats_idle");
    drive(4'hF, 1'b0, 8'd3);
    cyc("stats_wake");
    drive(4'hE, 1'b0, 8'd3);
    for (int i = 0; i < 2; i++) cyc("stats_tail");
    check32("stats_total10", total_cycles, 32'd10);
    check32("stats_gated4", gated_cycles, 32'd4);
`endif

    // Randomized traffic with occasional threshold changes and mid-cycle resets.
    drive(4'h0, 1'b0, 8'd3);
    for (int n = 0; n < 3000; n++) begin
      logic [ND-1:0] a;
      for (int i = 0; i < ND; i++) a[i] = ($urandom_range(99) < 20);
      if ($urandom_range(49) == 0) begin
        case ($urandom_range(4))
          0: idle_thresh = 8'd0;
          1: idle_thresh = 8'd1;
          2: idle_thresh = 8'd2;
          3: idle_thresh = 8'd3;
          default: idle_thresh = 8'($urandom_range(8, 4));
        endcase
      end
      activity = a;
      force_on = ($urandom_range(99) < 3);
      cyc("random");
      if ($urandom_range(299) == 0) mid_reset("random_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
